// File: rtl/mipi_csi2_des_if.sv
// mipi_csi2_des_if
//   Groups the byte-stream input and the pixel/frame status outputs of the
//   CSI-2 packet deserializer.
//   master : byte source side (drives hs_active/byte_valid/byte_data,
//            observes pixel stream and status)
//   slave  : deserializer side (receives bytes, drives pixels and status)
//   Signals:
//     hs_active  HS burst in progress (falling edge = end of transmission)
//     byte_valid byte_data valid this cycle
//     byte_data  received packet byte
//     pix_data   pixel, RAW8 right-aligned with upper bits zero
//     pix_valid  pix_data valid
//     vsync      frame active
//     href       line payload active
//     frame_num  WC field of the last Frame Start packet
//     line_cnt   long packets received since Frame Start
//     err_trunc  one-cycle pulse, burst ended mid-packet
//     err_size   one-cycle pulse, RAW10 WC not a multiple of 5
interface mipi_csi2_des_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  hs_active;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  vsync;
  logic                  href;
  logic [15:0]           frame_num;
  logic [15:0]           line_cnt;
  logic                  err_trunc;
  logic                  err_size;

  modport master (
    output hs_active, byte_valid, byte_data,
    input  pix_data, pix_valid, vsync, href, frame_num, line_cnt,
           err_trunc, err_size
  );

  modport slave (
    input  hs_active, byte_valid, byte_data,
    output pix_data, pix_valid, vsync, href, frame_num, line_cnt,
           err_trunc, err_size
  );
endinterface

// File: rtl/mipi_csi2_des.sv
// mipi_csi2_des
//   Parses a CSI-2 byte stream (one lane-merged byte per clk_hs) into
//   packets, tracks Frame Start / Frame End, and unpacks RAW8 / RAW10 long
//   packet payloads into a one-pixel-per-cycle stream.
//   Ports:
//     clk_hs  byte clock, the only clock
//     resetb  synchronous active-low reset
//     enable  block enable; low acts as reset on the next edge
//     bus     mipi_csi2_des_if.slave (byte input, pixel/status outputs)
module mipi_csi2_des #(
  parameter int DATA_WIDTH = 10
) (
  input  logic           clk_hs,
  input  logic           resetb,
  input  logic           enable,
  mipi_csi2_des_if.slave bus
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_DI       = 4'd1;
  localparam logic [3:0] ST_WC0      = 4'd2;
  localparam logic [3:0] ST_WC1      = 4'd3;
  localparam logic [3:0] ST_ECC      = 4'd4;
  localparam logic [3:0] ST_PAYLOAD  = 4'd5;
  localparam logic [3:0] ST_CS0      = 4'd6;
  localparam logic [3:0] ST_CS1      = 4'd7;
  localparam logic [3:0] ST_WAIT_EOT = 4'd8;

  localparam logic [7:0] DI_FS    = 8'h00;
  localparam logic [7:0] DI_FE    = 8'h01;
  localparam logic [7:0] DI_RAW8  = 8'h2A;
  localparam logic [7:0] DI_RAW10 = 8'h2B;

  logic [3:0]            state, state_n;
  logic [7:0]            di;
  logic [15:0]           wc;
  logic [15:0]           remaining, rem_n;
  logic [2:0]            grp_idx, grp_next, grp_n;
  logic [7:0]            msb [4];
  logic [DATA_WIDTH-1:0] hold [3];
  logic [1:0]            hold_cnt;

  logic trunc, take, pay, hdr_done, is_raw8, is_raw10;
  logic emit8, load10, drain, emit_n, size_err, more_pix, href_n;

  logic [DATA_WIDTH-1:0] pix_p1;
  logic                  vld_p1;
  logic                  href_p1;
  logic                  vsync_r;
  logic [15:0]           frame_num_r;
  logic [15:0]           line_cnt_r;
  logic                  err_trunc_r;
  logic                  err_size_r;

  function automatic logic [DATA_WIDTH-1:0] raw8_pix(input logic [7:0] b);
    return DATA_WIDTH'(b);
  endfunction

  // Pixel k of a RAW10 group: MSB byte k, LSB pair from bits [2k+1:2k] of byte 4.
  function automatic logic [DATA_WIDTH-1:0] raw10_pix(input logic [7:0] m,
                                                      input logic [7:0] l,
                                                      input logic [1:0] k);
    logic [9:0] p;
    p = {m, l[{k, 1'b0} +: 2]};
    return DATA_WIDTH'(p);
  endfunction

  always_comb begin
    is_raw8  = (di == DI_RAW8);
    is_raw10 = (di == DI_RAW10);
    state_n  = state;
    trunc    = 1'b0;
    take     = 1'b0;
    case (state)
      ST_IDLE:     if (bus.hs_active) state_n = ST_DI;
      ST_WAIT_EOT: if (!bus.hs_active) state_n = ST_IDLE;
      default: begin
        // Losing hs_active inside a packet wins over any byte in that cycle.
        if (!bus.hs_active) begin
          trunc   = 1'b1;
          state_n = ST_IDLE;
        end else if (bus.byte_valid) begin
          take = 1'b1;
          case (state)
            ST_DI:      state_n = ST_WC0;
            ST_WC0:     state_n = ST_WC1;
            ST_WC1:     state_n = ST_ECC;
            ST_ECC: begin
              if (di < 8'h10)       state_n = ST_WAIT_EOT;
              else if (wc == 16'd0) state_n = ST_CS0;
              else                  state_n = ST_PAYLOAD;
            end
            ST_PAYLOAD: if (remaining == 16'd1) state_n = ST_CS0;
            ST_CS0:     state_n = ST_CS1;
            ST_CS1:     state_n = ST_WAIT_EOT;
            default:    state_n = ST_IDLE;
          endcase
        end
      end
    endcase

    hdr_done = take && (state == ST_ECC);
    pay      = take && (state == ST_PAYLOAD);
    grp_next = (grp_idx == 3'd4) ? 3'd0 : grp_idx + 3'd1;
    emit8    = pay && is_raw8;
    load10   = pay && is_raw10 && (grp_idx == 3'd4);
    drain    = !trunc && (hold_cnt != 2'd0) && !load10;
    emit_n   = emit8 || load10 || drain;
    // Partial trailing group: the last payload byte leaves the group index mid-group.
    size_err = pay && is_raw10 && (remaining == 16'd1) && (grp_next != 3'd0);

    rem_n = hdr_done ? wc : (pay ? remaining - 16'd1 : remaining);
    grp_n = hdr_done ? 3'd0 : ((pay && is_raw10) ? grp_next : grp_idx);
    // href bridges byte gaps only while the line can still produce pixels;
    // a RAW10 tail shorter than a full group produces none.
    more_pix = (state_n == ST_PAYLOAD) &&
               (is_raw8 || (is_raw10 && (({1'b0, rem_n} + 17'(grp_n)) >= 17'd5)));
    href_n   = !trunc && (emit_n || (href_p1 && more_pix));
  end

  // Stage p1: control, status and registered pixel output
  always_ff @(posedge clk_hs) begin
    if (!resetb || !enable) begin
      state       <= ST_IDLE;
      hold_cnt    <= 2'd0;
      pix_p1      <= '0;
      vld_p1      <= 1'b0;
      href_p1     <= 1'b0;
      vsync_r     <= 1'b0;
      frame_num_r <= 16'd0;
      line_cnt_r  <= 16'd0;
      err_trunc_r <= 1'b0;
      err_size_r  <= 1'b0;
    end else begin
      state       <= state_n;
      err_trunc_r <= trunc;
      err_size_r  <= size_err;
      vld_p1      <= emit_n;
      href_p1     <= href_n;

      if (trunc)       hold_cnt <= 2'd0;
      else if (load10) hold_cnt <= 2'd3;
      else if (drain)  hold_cnt <= hold_cnt - 2'd1;

      if (emit8)       pix_p1 <= raw8_pix(bus.byte_data);
      else if (load10) pix_p1 <= raw10_pix(msb[0], bus.byte_data, 2'd0);
      else if (drain)  pix_p1 <= hold[0];

      // Every long packet counts as a line, pixel-bearing or not.
      if (hdr_done) begin
        if (di == DI_FS) begin
          vsync_r     <= 1'b1;
          frame_num_r <= wc;
          line_cnt_r  <= 16'd0;
        end else if (di == DI_FE) begin
          vsync_r <= 1'b0;
        end else if (di >= 8'h10) begin
          line_cnt_r <= line_cnt_r + 16'd1;
        end
      end
    end
  end

  // Stage p0: packet header, payload counters and RAW10 staging
  always_ff @(posedge clk_hs) begin
    if (take) begin
      case (state)
        ST_DI:   di        <= bus.byte_data;
        ST_WC0:  wc[7:0]   <= bus.byte_data;
        ST_WC1:  wc[15:8]  <= bus.byte_data;
        default: ;
      endcase
    end
    remaining <= rem_n;
    grp_idx   <= grp_n;
    // MSB bytes go to their own store so the next group can arrive while
    // the holding register is still draining.
    if (pay && is_raw10 && (grp_idx != 3'd4)) msb[grp_idx[1:0]] <= bus.byte_data;
    if (load10) begin
      hold[0] <= raw10_pix(msb[1], bus.byte_data, 2'd1);
      hold[1] <= raw10_pix(msb[2], bus.byte_data, 2'd2);
      hold[2] <= raw10_pix(msb[3], bus.byte_data, 2'd3);
    end else if (drain) begin
      hold[0] <= hold[1];
      hold[1] <= hold[2];
    end
  end

  assign bus.pix_data  = pix_p1;
  assign bus.pix_valid = vld_p1;
  assign bus.href      = href_p1;
  assign bus.vsync     = vsync_r;
  assign bus.frame_num = frame_num_r;
  assign bus.line_cnt  = line_cnt_r;
  assign bus.err_trunc = err_trunc_r;
  assign bus.err_size  = err_size_r;

endmodule

// File: tb/tb_mipi_csi2_des.sv
// Bench for mipi_csi2_des: directed bursts plus randomized bursts, each
// checked against a packet-level model of the expected pixels and status.
module tb_mipi_csi2_des;
  localparam int DATA_WIDTH = 10;

  logic clk_hs = 1'b0;
  logic resetb;
  logic enable;
  always #5 clk_hs = ~clk_hs;

  mipi_csi2_des_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  mipi_csi2_des #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_hs (clk_hs),
    .resetb (resetb),
    .enable (enable),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [DATA_WIDTH-1:0] got_q[$];
  int                    got_cyc[$];
  int ncyc     = 0;
  int href_tot = 0;
  int et_tot   = 0;
  int es_tot   = 0;

  always @(negedge clk_hs) begin
    ncyc <= ncyc + 1;
    if (bus.pix_valid === 1'b1) begin
      got_q.push_back(bus.pix_data);
      got_cyc.push_back(ncyc);
    end
    if (bus.href === 1'b1)      href_tot <= href_tot + 1;
    if (bus.err_trunc === 1'b1) et_tot   <= et_tot + 1;
    if (bus.err_size === 1'b1)  es_tot   <= es_tot + 1;
  end

  // Frame-level reference state.
  logic        mvsync = 1'b0;
  logic [15:0] mframe = 16'd0;
  logic [15:0] mline  = 16'd0;

  function automatic logic [63:0] outs_vec();
    return 64'({bus.pix_data, bus.pix_valid, bus.vsync, bus.href, bus.frame_num,
                bus.line_cnt, bus.err_trunc, bus.err_size});
  endfunction

  task automatic cyc();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.byte_valid = 1'b0;
      cyc();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    cyc();
    bus.byte_valid = 1'b0;
  endtask

  // Sends one burst (optionally cut after stop_at bytes) and checks it.
  task automatic run_burst(input logic [7:0] pk[$], input int stop_at, input bit gaps,
                           input bit bv_drop, input string tag);
    int s_pix, s_href, s_et, s_es, n_sent, wc, plen, navail, ngot, viol, v;
    logic [7:0] di;
    bit trunc;
    logic [DATA_WIDTH-1:0] exp_q[$];

    s_pix  = got_q.size();
    s_href = href_tot;
    s_et   = et_tot;
    s_es   = es_tot;

    bus.hs_active  = 1'b1;
    bus.byte_valid = 1'b0;
    cyc();
    n_sent = pk.size();
    if (stop_at >= 0 && stop_at < n_sent) n_sent = stop_at;
    for (int i = 0; i < n_sent; i++) put_byte(pk[i], gaps);
    bus.hs_active  = 1'b0;
    bus.byte_valid = bv_drop;
    bus.byte_data  = 8'($urandom);
    cyc();
    bus.byte_valid = 1'b0;
    repeat (8) cyc();

    di    = pk[0];
    wc    = int'(pk[1]) + 256 * int'(pk[2]);
    plen  = (di >= 8'h10) ? 6 + wc : 4;
    trunc = (n_sent < plen);
    if (n_sent >= 4) begin
      if (di == 8'h00) begin
        mvsync = 1'b1;
        mframe = 16'(wc);
        mline  = 16'd0;
      end else if (di == 8'h01) begin
        mvsync = 1'b0;
      end else if (di >= 8'h10) begin
        mline = mline + 16'd1;
      end
    end
    navail = (n_sent > 4) ? n_sent - 4 : 0;
    if (navail > wc) navail = wc;
    if (di == 8'h2A)
      for (int i = 0; i < navail; i++) exp_q.push_back(DATA_WIDTH'(pk[4 + i]));
    if (di == 8'h2B)
      for (int g = 0; g < navail / 5; g++)
        for (int k = 0; k < 4; k++) begin
          v = (int'(pk[4 + 5*g + k]) << 2) | ((int'(pk[4 + 5*g + 4]) >> (2*k)) & 3);
          exp_q.push_back(DATA_WIDTH'(v));
        end

    ngot = got_q.size() - s_pix;
    check({tag, ".npix"}, 64'(ngot), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ngot; i++)
      check($sformatf("%s.pix%0d", tag, i), 64'(got_q[s_pix + i]), 64'(exp_q[i]));
    check({tag, ".err_trunc"}, 64'(et_tot - s_et), trunc ? 64'd1 : 64'd0);
    check({tag, ".err_size"}, 64'(es_tot - s_es),
          (di == 8'h2B && !trunc && (wc % 5) != 0) ? 64'd1 : 64'd0);
    check({tag, ".vsync"}, 64'(bus.vsync), 64'(mvsync));
    check({tag, ".frame_num"}, 64'(bus.frame_num), 64'(mframe));
    check({tag, ".line_cnt"}, 64'(bus.line_cnt), 64'(mline));
    check({tag, ".href_end"}, 64'(bus.href), 64'd0);
    if (!trunc && exp_q.size() > 0 && ngot == exp_q.size()) begin
      check({tag, ".href_len"}, 64'(href_tot - s_href),
            64'(got_cyc[s_pix + ngot - 1] - got_cyc[s_pix] + 1));
      if (di == 8'h2B) begin
        viol = 0;
        for (int g = 0; g < ngot / 4; g++)
          if (got_cyc[s_pix + 4*g + 3] - got_cyc[s_pix + 4*g] != 3) viol++;
        check({tag, ".r10_consec"}, 64'(viol), 64'd0);
      end
    end
  endtask

  task automatic rand_burst(input int idx);
    logic [7:0] pk[$];
    logic [7:0] di;
    logic [15:0] w;
    int sel, stop_at, nj;
    sel = $urandom_range(0, 5);
    case (sel)
      0: di = 8'h00;
      1: di = 8'h01;
      2: di = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h0A;
      3: di = 8'h2A;
      4: di = 8'h2B;
      default: di = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h30;
    endcase
    case (sel)
      0, 1, 2: w = 16'($urandom_range(0, 65535));
      3:       w = 16'($urandom_range(0, 16));
      4:       w = 16'($urandom_range(0, 23));
      default: w = 16'($urandom_range(0, 8));
    endcase
    pk.push_back(di);
    pk.push_back(w[7:0]);
    pk.push_back(w[15:8]);
    pk.push_back(8'($urandom));
    if (di >= 8'h10) begin
      for (int i = 0; i < int'(w); i++) pk.push_back(8'($urandom));
      pk.push_back(8'($urandom));
      pk.push_back(8'($urandom));
    end else begin
      nj = $urandom_range(0, 2);
      for (int i = 0; i < nj; i++) pk.push_back(8'($urandom));
    end
    stop_at = -1;
    if (sel != 4 && $urandom_range(0, 4) == 0) stop_at = $urandom_range(0, pk.size() - 1);
    run_burst(pk, stop_at, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              $sformatf("rnd%0d", idx));
  endtask

  logic [7:0] dq[$];
  int s;

  initial begin
    resetb         = 1'b0;
    enable         = 1'b1;
    bus.hs_active  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) cyc();
    @(negedge clk_hs);
    check("reset_outs", outs_vec(), 64'd0);
    resetb = 1'b1;
    cyc();

    dq = '{8'h00, 8'h05, 8'h00, 8'hEC};
    run_burst(dq, -1, 1'b0, 1'b0, "fs");
    check("fs.frame_const", 64'(bus.frame_num), 64'h0005);

    dq = '{8'h2A, 8'h04, 8'h00, 8'hEC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hCD, 8'hAB};
    run_burst(dq, -1, 1'b0, 1'b0, "raw8");
    check("raw8.line_const", 64'(bus.line_cnt), 64'd1);

    s  = got_q.size();
    dq = '{8'h2B, 8'h05, 8'h00, 8'hEC, 8'h80, 8'h81, 8'h82, 8'h83, 8'hE4, 8'hCD, 8'hAB};
    run_burst(dq, -1, 1'b0, 1'b0, "raw10");
    if (got_q.size() >= s + 4) begin
      check("raw10.c0", 64'(got_q[s]),     64'h200);
      check("raw10.c3", 64'(got_q[s + 3]), 64'h20F);
    end else begin
      check("raw10.count", 64'(got_q.size() - s), 64'd4);
    end

    dq = '{8'h2B, 8'h07, 8'h00, 8'hEC, 8'h40, 8'h41, 8'h42, 8'h43, 8'h1B,
           8'h55, 8'h66, 8'hCD, 8'hAB};
    run_burst(dq, -1, 1'b0, 1'b0, "raw10_wc7");

    dq = '{8'h2A, 8'h04, 8'h00, 8'hEC, 8'h21, 8'h22, 8'h23, 8'h24, 8'hCD, 8'hAB};
    run_burst(dq, 6, 1'b0, 1'b1, "trunc");
    dq = '{8'h01, 8'h00, 8'h00, 8'hEC};
    run_burst(dq, -1, 1'b0, 1'b0, "fe");
    check("fe.vsync_const", 64'(bus.vsync), 64'd0);

    // Reset in the middle of a RAW8 payload.
    dq = '{8'h00, 8'h09, 8'h00, 8'hEC};
    run_burst(dq, -1, 1'b0, 1'b0, "fs2");
    bus.hs_active = 1'b1;
    cyc();
    dq = '{8'h2A, 8'h04, 8'h00, 8'hEC, 8'h55};
    for (int i = 0; i < dq.size(); i++) put_byte(dq[i], 1'b0);
    resetb = 1'b0;
    cyc();
    @(negedge clk_hs);
    check("rst_mid.outs", outs_vec(), 64'd0);
    mvsync = 1'b0; mframe = 16'd0; mline = 16'd0;
    s = got_q.size();
    bus.hs_active = 1'b0;
    resetb = 1'b1;
    repeat (4) cyc();
    check("rst_mid.nopix", 64'(got_q.size() - s), 64'd0);
    dq = '{8'h00, 8'h34, 8'h12, 8'hEC};
    run_burst(dq, -1, 1'b0, 1'b0, "fs_after_rst");

    // Enable dropped while a RAW10 group is still draining.
    bus.hs_active = 1'b1;
    cyc();
    dq = '{8'h2B, 8'h0A, 8'h00, 8'hEC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < dq.size(); i++) put_byte(dq[i], 1'b0);
    enable = 1'b0;
    cyc();
    @(negedge clk_hs);
    check("en_low.outs", outs_vec(), 64'd0);
    mvsync = 1'b0; mframe = 16'd0; mline = 16'd0;
    s = got_q.size();
    bus.hs_active = 1'b0;
    enable = 1'b1;
    repeat (4) cyc();
    check("en_low.nopix", 64'(got_q.size() - s), 64'd0);
    dq = '{8'h00, 8'h77, 8'h00, 8'hEC};
    run_burst(dq, -1, 1'b0, 1'b0, "fs_after_en");

    for (int i = 0; i < 40; i++) rand_burst(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mipi_csi2_des.md
MIPI_CSI2_DES -- requirements
Module: mipi_csi2_des

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, width of the pix_data output (one pixel).
REQ-002 SHALL have ports, clock and reset first:
- clk_hs  in  1  byte clock; the only clock.
- resetb  in  1  reset, synchronous, active-low.
- enable  in  1  block enable.
- hs_active  in  1  high while a HS burst is in progress; falling edge = EoT.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  received packet byte.
- pix_data  out  DATA_WIDTH  pixel; RAW8 right-aligned, upper bits zero.
- pix_valid  out  1  pix_data valid.
- vsync  out  1  frame active.
- href  out  1  line payload active.
- frame_num  out  16  WC field of the last Frame Start packet.
- line_cnt  out  16  long packets received since Frame Start.
- err_trunc  out  1  one-cycle pulse: burst ended mid-packet.
- err_size  out  1  one-cycle pulse: RAW10 WC not a multiple of 5.

Function
REQ-003 SHALL parse packets with the FSM states ST_IDLE, ST_DI, ST_WC0, ST_WC1, ST_ECC, ST_PAYLOAD, ST_CS0, ST_CS1, ST_WAIT_EOT, and advance only on cycles with byte_valid=1.
REQ-004 SHALL move ST_IDLE -> ST_DI when hs_active=1. The first valid byte is the DI; the next two are WC LSB then MSB; the next is ECC (captured, not checked).
REQ-005 SHALL decode DI 0x00 (Frame Start) after the ECC byte as follows: vsync<=1, frame_num<=WC, line_cnt<=0.
REQ-006 SHALL decode DI 0x01 (Frame End) after the ECC byte as vsync<=0.
REQ-007 SHALL accept DI 0x02, DI 0x03 and any other short DI (<0x10) without side effects.
REQ-008 SHALL go to ST_WAIT_EOT after the ECC byte of any short packet.
REQ-009 SHALL treat DI 0x2A (RAW8) and DI 0x2B (RAW10) as long packets. After the ECC byte: line_cnt+1, go to ST_PAYLOAD with a 16-bit remaining count = WC; if WC=0, go directly to ST_CS0.
REQ-010 SHALL treat any other DI >= 0x10 as a long packet and consume its WC payload bytes with no pixel output.
REQ-011 SHALL decrement the remaining count per payload byte and go to ST_CS0 after the byte that makes it 0.
REQ-012 SHALL capture two checksum bytes (CS0 LSB, CS1 MSB) without checking them, then go to ST_WAIT_EOT.
REQ-013 SHALL, in ST_WAIT_EOT, ignore bytes until hs_active=0, then go to ST_IDLE.
REQ-014 SHALL, for RAW8, output pix_valid=1 with pix_data={0,byte} the cycle after each payload byte is accepted.
REQ-015 SHALL, for RAW10, unpack 5-byte groups. Bytes 0-3 are pixel MSBs [9:2]. Byte 4 holds the LSBs: pixel k uses bits [2k+1:2k].
REQ-016 SHALL, on acceptance of RAW10 byte 4, load the 4 pixels into an output holding register and emit them one per cycle (pixel 0 first) starting the next cycle. MSB bytes of the next group SHALL be stored separately, so there is no stall and no loss at full byte rate.
REQ-017 SHALL raise href with the first pix_valid of a line and drop it the cycle after the last pix_valid of that line.
REQ-018 SHALL handle RAW10 WC not a multiple of 5 as follows: discard the trailing partial group, pulse err_size once at CS0 entry, and emit no partial pixels.
REQ-019 SHALL handle hs_active=0 in any state other than ST_IDLE/ST_WAIT_EOT as follows: pulse err_trunc, discard undrained pixels, href<=0, go to ST_IDLE; vsync is unchanged.
REQ-020 SHALL give hs_active=0 with byte_valid=1 in the same cycle the truncation rule (REQ-019); the byte is ignored.
REQ-021 SHALL, on enable=0, behave as reset on the next clk_hs edge and ignore inputs.
REQ-022 SHALL wrap line_cnt modulo 2^16.

Reset
REQ-023 SHALL, when resetb=0 at a clk_hs edge, set the FSM to ST_IDLE and clear all outputs to 0: pix_data, pix_valid, vsync, href, frame_num, line_cnt, err_trunc, err_size.
REQ-024 SHALL, on reset mid-packet, abandon the packet and emit no pixels; the first packet after release is parsed from its DI.

Verification
REQ-025 Burst 00 05 00 EC -> vsync=1, frame_num=0x0005, line_cnt=0, no errors.
REQ-026 Burst 2A 04 00 EC 11 22 33 44 CD AB -> 4 pix_valid pulses 0x011,0x022,0x033,0x044; href high exactly those cycles; line_cnt=1.
REQ-027 Burst 2B 05 00 EC 80 81 82 83 E4 CD AB -> pixels 0x200,0x205,0x20A,0x20F on 4 consecutive cycles after E4.
REQ-028 RAW10 WC=7 -> 4 pixels, 2 bytes dropped, single err_size pulse.
REQ-029 hs_active falls after 2 RAW8 payload bytes of WC=4 -> 2 pixels, err_trunc pulse, href=0, next burst 01 00 00 EC -> vsync=0.
REQ-030 resetb=0 during payload -> all outputs 0 next cycle; next Frame Start parses correctly.
